// File: rtl/button_event_decoder_if.sv
// Event-side bundle of button_event_decoder: debounced level plus the
// registered gesture event (valid strobe, code, measured duration).
// The decoder drives it through the master modport; consumers use slave.
interface button_event_decoder_if;
   logic        pressed;
   logic        event_valid;
   logic [1:0]  event_code;
   logic [31:0] press_duration;

   modport master (
      output pressed,
      output event_valid,
      output event_code,
      output press_duration
   );

   modport slave (
      input pressed,
      input event_valid,
      input event_code,
      input press_duration
   );
endinterface

// File: rtl/button_event_decoder.sv
// button_event_decoder: synchronizes and debounces a raw push-button pin,
// measures press lengths and classifies gestures as SHORT, LONG or DOUBLE.
// Each gesture is reported as a one-cycle event with a code and duration.
// Optional macro BUTTON_EVENT_DECODER_REPEAT_EN adds auto-repeat (code 11)
// while a LONG press stays held; without it HOLD only waits for release.
module button_event_decoder #(
   parameter int          SYNC_STAGES   = 2,
   parameter logic [31:0] REPEAT_CYCLES = 32'd10_000_000
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          enable,
   input  logic [31:0]                   debounce_cycles,
   input  logic [31:0]                   long_press,
   input  logic [31:0]                   double_gap,
   input  logic                          BUTTON_IN,
   button_event_decoder_if.master        evt
);

   typedef enum logic [1:0] {IDLE, PRESS, GAP, HOLD} state_t;

   localparam logic [1:0] CODE_SHORT  = 2'b00;
   localparam logic [1:0] CODE_LONG   = 2'b01;
   localparam logic [1:0] CODE_DOUBLE = 2'b10;
   localparam logic [1:0] CODE_REPEAT = 2'b11;

   // Parameter sanity, caught at elaboration.
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (REPEAT_CYCLES == 32'd0) begin : g_bad_repeat
      $error("REPEAT_CYCLES must be at least 1");
   end

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   sync_in;
   logic                   btn_db;
   logic                   btn_db_q;
   logic [31:0]            db_cnt;
   logic [31:0]            db_limit;
   logic                   rise;
   logic                   fall;
   logic [31:0]            dur_cnt;
   logic [31:0]            gap_cnt;
   logic [31:0]            first_len;
   logic                   long_hit;
   logic                   gap_hit;
   state_t                 state;
   state_t                 state_next;
   logic                   emit;
   logic [1:0]             emit_code;
   logic [31:0]            emit_dur;

   // Metastability chain on the asynchronous pin.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sync_ff <= '0;
      else         sync_ff <= {sync_ff[SYNC_STAGES-2:0], BUTTON_IN};
   end

   assign sync_in  = sync_ff[SYNC_STAGES-1];
   assign db_limit = (debounce_cycles == 32'd0) ? 32'd1 : debounce_cycles;

   // Debouncer: accept a new level only after it persists up to db_limit; runs regardless of enable.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         btn_db <= 1'b0;
         db_cnt <= '0;
      end else if (sync_in == btn_db) begin
         db_cnt <= '0;
      end else if (db_cnt == db_limit) begin
         btn_db <= ~btn_db;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 32'd1;
      end
   end

   // Edge detect history, press-length and release-gap counters, first-press latch.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         btn_db_q  <= 1'b0;
         dur_cnt   <= '0;
         gap_cnt   <= '0;
         first_len <= '0;
      end else begin
         btn_db_q <= btn_db;
         if (rise)                                 dur_cnt <= 32'd1;
         else if (btn_db && dur_cnt != '1)         dur_cnt <= dur_cnt + 32'd1;
         gap_cnt <= (state == GAP) ? gap_cnt + 32'd1 : 32'd0;
         if (state == PRESS && fall)               first_len <= dur_cnt;
      end
   end

   assign rise     = btn_db & ~btn_db_q;
   assign fall     = ~btn_db & btn_db_q;
   assign long_hit = (long_press != 32'd0) && (dur_cnt == long_press) && btn_db;
   assign gap_hit  = (gap_cnt == double_gap);

`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
   logic        via_long;
   logic [31:0] rep_cnt;
   logic        rep_hit;

   assign rep_hit = (rep_cnt == REPEAT_CYCLES - 32'd1);

   // Repeat timer: armed only for a HOLD that was entered through a LONG event.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         via_long <= 1'b0;
         rep_cnt  <= '0;
      end else if (state != HOLD) begin
         via_long <= (state == PRESS) && (state_next == HOLD);
         rep_cnt  <= '0;
      end else begin
         rep_cnt  <= rep_hit ? 32'd0 : rep_cnt + 32'd1;
      end
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // FSM next-state logic; enable low forces IDLE and drops any gesture.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      if (!enable) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE:  if (rise) state_next = PRESS;
            PRESS: begin
               if (long_hit)  state_next = HOLD;
               else if (fall) state_next = (double_gap == 32'd0) ? IDLE : GAP;
            end
            GAP: begin
               if (rise)         state_next = HOLD;
               else if (gap_hit) state_next = IDLE;
            end
            HOLD:  if (!btn_db) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // FSM output logic: which event, if any, qualifies this cycle.
   always_comb begin
      emit      = 1'b0;
      emit_code = CODE_SHORT;
      emit_dur  = dur_cnt;
      if (enable) begin
         unique case (state)
            PRESS: begin
               if (long_hit) begin
                  emit      = 1'b1;
                  emit_code = CODE_LONG;
               end else if (fall && double_gap == 32'd0) begin
                  emit      = 1'b1;
               end
            end
            GAP: begin
               emit_dur = first_len;
               if (rise) begin
                  emit      = 1'b1;
                  emit_code = CODE_DOUBLE;
               end else if (gap_hit) begin
                  emit      = 1'b1;
               end
            end
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
            HOLD: begin
               if (via_long && btn_db && rep_hit) begin
                  emit      = 1'b1;
                  emit_code = CODE_REPEAT;
               end
            end
`endif
            default: emit = 1'b0;
         endcase
      end
   end

   // Registered event outputs; code and duration hold until the next event.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         evt.event_valid    <= 1'b0;
         evt.event_code     <= CODE_SHORT;
         evt.press_duration <= '0;
      end else begin
         evt.event_valid <= emit;
         if (emit) begin
            evt.event_code     <= emit_code;
            evt.press_duration <= emit_dur;
         end
      end
   end

   assign evt.pressed = btn_db;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: clean press, bounce rejection,
// LONG, DOUBLE and gap-expiry boundaries, enable and async reset mid-gesture,
// plus auto-repeat when BUTTON_EVENT_DECODER_REPEAT_EN is defined.
module tb_button_event_decoder;

   typedef struct {
      logic [1:0]  code;
      logic [31:0] dur;
      int          cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        enable;
   logic [31:0] debounce_cycles;
   logic [31:0] long_press;
   logic [31:0] double_gap;
   logic        button;

   int   tests  = 0;
   int   failed = 0;
   int   cyc    = 0;
   int   pressed_cnt = 0;
   int   pressed_rise_cyc = -1;
   logic pressed_prev = 1'b0;
   ev_t  evq[$];

   button_event_decoder_if evt();

   button_event_decoder #(
      .SYNC_STAGES   (2),
      .REPEAT_CYCLES (32'd100)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .enable          (enable),
      .debounce_cycles (debounce_cycles),
      .long_press      (long_press),
      .double_gap      (double_gap),
      .BUTTON_IN       (button),
      .evt             (evt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event and level monitor, sampled on the falling edge.
   always @(negedge clk) begin
      ev_t e;
      if (evt.pressed === 1'b1) pressed_cnt++;
      if (evt.pressed === 1'b1 && pressed_prev !== 1'b1 && pressed_rise_cyc < 0) pressed_rise_cyc = cyc;
      pressed_prev = evt.pressed;
      if (evt.event_valid === 1'b1) begin
         e.code = evt.event_code;
         e.dur  = evt.press_duration;
         e.cyc  = cyc;
         evq.push_back(e);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Compare one recorded event; cyc_exp < 0 skips the timing comparison.
   task automatic check_event(input string tag, input int idx, input logic [1:0] code,
                              input logic [31:0] dur, input int cyc_exp);
      if (idx < evq.size()) begin
         check({tag, "_code"}, 32'(evq[idx].code), 32'(code));
         check({tag, "_dur"}, evq[idx].dur, dur);
         if (cyc_exp >= 0) check({tag, "_cyc"}, evq[idx].cyc, cyc_exp);
      end else begin
         check({tag, "_missing"}, evq.size(), idx + 1);
      end
   endtask

   // All stimulus tasks start and end #1 after a rising edge.
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int n, output int start);
      button = 1'b1;
      start  = cyc;
      idle(n);
      button = 1'b0;
   endtask

   task automatic clear_log();
      evq.delete();
      pressed_cnt      = 0;
      pressed_rise_cyc = -1;
   endtask

   initial begin
      int s0;
      int s1;
      int long_events;

      resetn          = 1'b0;
      enable          = 1'b0;
      button          = 1'b0;
      debounce_cycles = 32'd4;
      long_press      = 32'd1000;
      double_gap      = 32'd0;
      idle(3);
      check("rst_pressed", 32'(evt.pressed), 32'd0);
      check("rst_valid",   32'(evt.event_valid), 32'd0);
      check("rst_code",    32'(evt.event_code), 32'd0);
      check("rst_dur",     evt.press_duration, 32'd0);
      resetn = 1'b1;
      enable = 1'b1;
      idle(5);

      // Clean 100-cycle press, SHORT with exact length and latency.
      clear_log();
      press(100, s0);
      idle(30);
      check("clean_count", evq.size(), 32'd1);
      check_event("clean", 0, 2'b00, 32'd100, s0 + 108);
      check("clean_pressed_len", pressed_cnt, 32'd100);
      check("clean_pressed_lat", pressed_rise_cyc, s0 + 7);

      // Bounces of 1..8 cycles never pass an 8-cycle debouncer.
      debounce_cycles = 32'd8;
      clear_log();
      for (int g = 1; g <= 8; g++) begin
         press(g, s1);
         idle(20);
      end
      check("bounce_pressed", pressed_cnt, 32'd0);
      check("bounce_events", evq.size(), 32'd0);
      debounce_cycles = 32'd4;

      // LONG at 500 while held, nothing on release.
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
      long_events = 15;
`else
      long_events = 1;
`endif
      long_press = 32'd500;
      clear_log();
      press(2000, s0);
      idle(30);
      check("long_count", evq.size(), long_events);
      check_event("long", 0, 2'b01, 32'd500, s0 + 508);
      long_press = 32'd1000;

      // DOUBLE: 50 on, 100 off, 50 on, with gap limit 200.
      double_gap = 32'd200;
      clear_log();
      press(50, s0);
      idle(100);
      press(50, s1);
      idle(300);
      check("dbl_count", evq.size(), 32'd1);
      check_event("dbl", 0, 2'b10, 32'd50, -1);

      // Gap of 250 exceeds 200: SHORT at expiry, then a second SHORT.
      clear_log();
      press(50, s0);
      idle(250);
      press(50, s1);
      idle(300);
      check("gapx_count", evq.size(), 32'd2);
      check_event("gapx_first", 0, 2'b00, 32'd50, s0 + 259);
      check_event("gapx_second", 1, 2'b00, 32'd50, -1);

      // Boundary: rise lands on the expiry cycle, DOUBLE wins.
      double_gap = 32'd99;
      clear_log();
      press(50, s0);
      idle(100);
      press(50, s1);
      idle(300);
      check("tie_count", evq.size(), 32'd1);
      check_event("tie", 0, 2'b10, 32'd50, -1);

      // Boundary: expiry one cycle before the rise gives two SHORTs.
      double_gap = 32'd98;
      clear_log();
      press(50, s0);
      idle(100);
      press(60, s1);
      idle(300);
      check("early_count", evq.size(), 32'd2);
      check_event("early_first", 0, 2'b00, 32'd50, -1);
      check_event("early_second", 1, 2'b00, 32'd60, -1);

      // Enable dropped mid-press, raised while held: no event at all.
      double_gap = 32'd0;
      clear_log();
      button = 1'b1;
      idle(20);
      enable = 1'b0;
      idle(10);
      check("en_low_pressed", 32'(evt.pressed), 32'd1);
      enable = 1'b1;
      idle(30);
      button = 1'b0;
      idle(30);
      check("en_held_events", evq.size(), 32'd0);
      press(40, s0);
      idle(30);
      check("en_fresh_count", evq.size(), 32'd1);
      check_event("en_fresh", 0, 2'b00, 32'd40, s0 + 48);

      // Async reset in GAP after a LONG event clears outputs immediately.
      long_press = 32'd100;
      clear_log();
      press(150, s0);
      idle(30);
      long_press = 32'd1000;
      double_gap = 32'd200;
      press(50, s1);
      idle(50);
      check("pre_rst_code", 32'(evt.event_code), 32'd1);
      check("pre_rst_dur", evt.press_duration, 32'd100);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst_code", 32'(evt.event_code), 32'd0);
      check("async_rst_dur", evt.press_duration, 32'd0);
      check("async_rst_valid", 32'(evt.event_valid), 32'd0);
      idle(2);
      resetn = 1'b1;
      idle(300);
      check("post_rst_events", evq.size(), 32'd1);
      double_gap = 32'd0;

`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
      // LONG at 300, REPEAT every 100 cycles, nothing after release.
      long_press = 32'd300;
      clear_log();
      press(650, s0);
      idle(30);
      check("rep_count", evq.size(), 32'd4);
      check_event("rep_long", 0, 2'b01, 32'd300, s0 + 308);
      check_event("rep_1", 1, 2'b11, 32'd400, s0 + 408);
      check_event("rep_2", 2, 2'b11, 32'd500, s0 + 508);
      check_event("rep_3", 3, 2'b11, 32'd600, s0 + 608);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
